// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: drives an external shift_reg one bit per clock to implement
// LSL/LSR/ASR/ROR by a variable amount, returning result and shifter carry-out.
module shift_seq #(
  parameter int unsigned width = 8,
  parameter int unsigned shw   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] op_data,
  input  logic [shw-1:0]   shamt,
  input  logic [1:0]       shtype,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] result,
  output logic             carry_out,
  output logic             sr_reset,
  output logic             sr_ps,
  output logic             sr_rl,
  output logic             sr_serial_left,
  output logic             sr_serial_right,
  output logic [width-1:0] sr_data,
  input  logic [width-1:0] sr_out
);

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e           state_q, state_d;
  logic [width-1:0] op_q, op_d;
  logic [shw-1:0]   shamt_q, shamt_d;
  logic [1:0]       shtype_q, shtype_d;
  logic [shw-1:0]   cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [width-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    shamt_d         = shamt_q;
    shtype_d        = shtype_q;
    cnt_d           = cnt_q;
    c_d             = c_q;
    result_d        = result_q;
    carry_d         = carry_q;
    done_d          = 1'b0;
    // Default is a parallel reload of the current value, which holds shift_reg still.
    sr_ps           = 1'b1;
    sr_rl           = 1'b0;
    sr_serial_left  = 1'b0;
    sr_serial_right = 1'b0;
    sr_data         = sr_out;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op_data;
          shamt_d  = shamt;
          shtype_d = shtype;
          c_d      = carry_in;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        sr_data = op_q;
        cnt_d   = shamt_q;
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q != '0) begin
          sr_ps = 1'b0;
          sr_rl = (shtype_q != ShLsl);
          unique case (shtype_q)
            ShLsl: sr_serial_right = 1'b0;
            ShLsr: sr_serial_left  = 1'b0;
            ShAsr: sr_serial_left  = sr_out[width-1];
            ShRor: sr_serial_left  = sr_out[0];
            default: sr_serial_left = 1'b0;
          endcase
          c_d   = (shtype_q == ShLsl) ? sr_out[width-1] : sr_out[0];
          cnt_d = cnt_q - shw'(1);
        end else begin
          result_d = sr_out;
          carry_d  = c_q;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      shamt_q  <= '0;
      shtype_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      shtype_q <= shtype_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign sr_reset  = reset;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the multi-cycle ARM datapath.
- Sits directly upstream of shift_reg. It loads an operand into shift_reg, then drives it one bit per cycle to perform LSL/LSR/ASR/ROR by a variable amount.
- Returns the result and the ARM shifter carry-out with a start/busy/done handshake.
- Shift_reg convention, which this block depends on:
  - ps=1: parallel load from DATA.
  - ps=0: shift every clock. There is no enable.
  - rl=1: shift right, serial_left enters the MSB.
  - rl=0: shift left, serial_right enters the LSB.

Parameters:
width, 8, operand/shift_reg width; must match the attached shift_reg.
shw, 4, width of the shift amount field.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op_data  in  width  operand to shift.
shamt  in  shw  shift amount, 0..2^shw-1.
shtype  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
carry_in  in  1  current C flag; returned when shamt=0.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse when result is valid.
result  out  width  shifted value; held until next done.
carry_out  out  1  last bit shifted out; held until next done.
sr_reset  out  1  to shift_reg reset; equals reset.
sr_ps  out  1  to shift_reg ps.
sr_rl  out  1  to shift_reg rl.
sr_serial_left  out  1  to shift_reg serial_left.
sr_serial_right  out  1  to shift_reg serial_right.
sr_data  out  width  to shift_reg DATA.
sr_out  in  width  from shift_reg out.

Behaviour:
- Reset, synchronous:
  - state=IDLE; result=0; carry_out=0; done=0; counter and captured fields cleared.
  - Reset mid-operation aborts immediately. No done pulse; result and carry_out go to 0.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - Drives sr_ps=1, sr_data=sr_out, which holds the shift_reg value.
  - On an edge with start=1: capture op_data, shamt, shtype and carry_in; set the carry tracker c=carry_in; go to LOAD.
- LOAD:
  - Drives sr_ps=1, sr_data=captured op_data.
  - At the edge: cnt<=shamt_q; go to SHIFT.
- SHIFT with cnt!=0:
  - Drive sr_ps=0 and sr_rl=0 for LSL, 1 otherwise.
  - LSL: sr_serial_right=0.
  - LSR: sr_serial_left=0.
  - ASR: sr_serial_left=sr_out[width-1].
  - ROR: sr_serial_left=sr_out[0].
  - At the edge: c<=sr_out[width-1] for LSL, else c<=sr_out[0]; cnt<=cnt-1.
  - Unused serial inputs are driven 0.
- SHIFT with cnt==0:
  - Drive the hold (sr_ps=1, sr_data=sr_out).
  - At the edge: result<=sr_out; carry_out<=c; done<=1; go to IDLE.
- done is a registered output, high for exactly one cycle, then cleared.
- Latency: done is high in the cycle after the (shamt+2)th rising edge following the edge that sampled start. busy covers exactly those shamt+2 cycles.
- start while busy is ignored, with no queueing. start in the done cycle is accepted, since state is already IDLE.
- shamt>=width iterates literally:
  - LSL/LSR give 0, with carry=0 once shamt>width.
  - ASR fills with the sign bit.
  - ROR wraps modulo width.
- shamt=0: result=op_data, carry_out=carry_in, done after 2 edges.
- Inputs other than start are don't-care outside the start edge.

Test Plan:
- width=8. LSL 0x81 by 1 -> result 0x02, carry_out 1; done high after 3rd edge; busy high 3 cycles.
- LSR 0x81 by 3 -> 0x10, carry 0. ASR 0x90 by 2 -> 0xE4, carry 0. ROR 0x81 by 1 -> 0xC0, carry 1.
- shamt=0, op 0x5A, carry_in=1, shtype=ROR -> 0x5A, carry_out 1, done after 2 edges. LSL 0xFF by 9 -> 0x00, carry 0.
- Start LSR 0xF0 by 4, pulse start with op 0x0F during SHIFT -> second request ignored; result 0x0F, carry 0; single done pulse.
- Start ASR 0x80 by 5, assert reset for one cycle at the 3rd edge -> busy/done/result/carry 0, no done. Then restart the same op -> 0xFC, carry 0.
- Back-to-back: start held high across done -> second operation accepted in the done cycle. Verify sr_ps=1 and sr_data=sr_out in every non-shift cycle, so shift_reg out stays stable while IDLE.
